// File: rtl/draw_bug.sv
// Sprite overlay on a VGA pixel stream; 3 clk latency, no backpressure (streaming video).
// Optional BUG_TRANSPARENT_EN: ROM pixels equal to KEY_COLOR show the background instead.
module draw_bug #(
    parameter int          SPRITE_W  = 64,
    parameter int          SPRITE_H  = 64,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [11:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

`ifdef BUG_TRANSPARENT_EN
    localparam logic TRANSP_EN = 1'b1;
`else
    localparam logic TRANSP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    timing_t     tim_in;
    timing_t     tim1_q, tim2_q, tim3_q;
    logic [11:0] rgbin1_q, rgbin2_q;
    logic        insp1_q, insp2_q;
    logic [10:0] xpos_q, ypos_q;
    logic        vblnk_prev_q;
    logic [11:0] addr_q, addr_d;
    logic [11:0] rgb_q, rgb_d;
    logic        in_sprite;
    logic        vblnk_rise;
    logic [11:0] h_ext, v_ext, x_ext, y_ext;
    logic [5:0]  dx, dy;
    logic        show_rom;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    // 12-bit compare so a sprite near the right/bottom edge is clipped, not wrapped.
    assign h_ext = {1'b0, hcount_in};
    assign v_ext = {1'b0, vcount_in};
    assign x_ext = {1'b0, xpos_q};
    assign y_ext = {1'b0, ypos_q};
    assign in_sprite = (h_ext >= x_ext) && (h_ext < x_ext + 12'(SPRITE_W)) &&
                       (v_ext >= y_ext) && (v_ext < y_ext + 12'(SPRITE_H));

    assign dx = hcount_in[5:0] - xpos_q[5:0];
    assign dy = vcount_in[5:0] - ypos_q[5:0];
    assign vblnk_rise = vblnk_in && !vblnk_prev_q;

    always_comb begin
        addr_d = 12'h000;
        if (in_sprite) begin
            addr_d = {dy, dx};
        end
    end

    assign show_rom = insp2_q && !(TRANSP_EN && (rgb_pixel == KEY_COLOR));

    always_comb begin
        rgb_d = rgbin2_q;
        if (tim2_q.hblnk || tim2_q.vblnk) begin
            rgb_d = 12'h000;
        end else if (show_rom) begin
            rgb_d = rgb_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tim1_q       <= '0;
            tim2_q       <= '0;
            tim3_q       <= '0;
            rgbin1_q     <= '0;
            rgbin2_q     <= '0;
            insp1_q      <= 1'b0;
            insp2_q      <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            vblnk_prev_q <= 1'b0;
            addr_q       <= '0;
            rgb_q        <= '0;
        end else begin
            tim1_q       <= tim_in;
            tim2_q       <= tim1_q;
            tim3_q       <= tim2_q;
            rgbin1_q     <= rgb_in;
            rgbin2_q     <= rgbin1_q;
            insp1_q      <= in_sprite;
            insp2_q      <= insp1_q;
            vblnk_prev_q <= vblnk_in;
            addr_q       <= addr_d;
            rgb_q        <= rgb_d;
            // Position only moves at frame start so the sprite never tears.
            if (vblnk_rise) begin
                xpos_q <= xpos;
                ypos_q <= ypos;
            end
        end
    end

    assign pixel_addr = addr_q;
    assign rgb_out    = rgb_q;
    assign hcount_out = tim3_q.hcount;
    assign vcount_out = tim3_q.vcount;
    assign hsync_out  = tim3_q.hsync;
    assign vsync_out  = tim3_q.vsync;
    assign hblnk_out  = tim3_q.hblnk;
    assign vblnk_out  = tim3_q.vblnk;

endmodule

// File: doc/draw_bug.md
DRAW_BUG -- requirements
Module: draw_bug

Interface
REQ-001 Parameter SPRITE_W, default 64: sprite width in pixels; fixed by the 6-bit x field of the ROM address.
REQ-002 Parameter SPRITE_H, default 64: sprite height in pixels; fixed by the 6-bit y field of the ROM address.
REQ-003 Parameter KEY_COLOR, default 12'hF0F: ROM colour treated as transparent when BUG_TRANSPARENT_EN is defined.
REQ-004 clk  in  1  system/pixel clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 hcount_in, vcount_in  in  11 each  VGA pixel coordinates.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing strobes.
REQ-008 rgb_in  in  12  background colour {r,g,b}.
REQ-009 xpos, ypos  in  11 each  requested top-left sprite position.
REQ-010 pixel_addr  out  12  ROM address {y[5:0], x[5:0]}, registered.
REQ-011 rgb_pixel  in  12  ROM data; valid one clk after pixel_addr.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed to match rgb_out.
REQ-013 rgb_out  out  12  composited pixel colour.

Function
REQ-014 Latency from any input sample to the corresponding outputs SHALL be exactly 3 clk: stage 1 registers address and timing, the ROM read takes one clk, stage 3 registers the composite.
REQ-015 Timing signals SHALL pass through a 3-deep register delay line unchanged in value.
REQ-016 Position SHALL be latched into xpos_r/ypos_r only on the clk where vblnk_in is 1 and the previous vblnk_in was 0; between such edges the latched value SHALL hold, so the sprite never tears mid-frame.
REQ-017 in_sprite SHALL be true iff hcount_in >= xpos_r, hcount_in < xpos_r+SPRITE_W, vcount_in >= ypos_r and vcount_in < ypos_r+SPRITE_H; sums SHALL be computed 12 bits wide, with no wrap-around.
REQ-018 A sprite extending past the visible area SHALL be clipped naturally; no pixel SHALL appear at the opposite edge.
REQ-019 pixel_addr SHALL be {vcount_in-ypos_r [5:0], hcount_in-xpos_r [5:0]} when in_sprite, else 12'h000.
REQ-020 in_sprite SHALL be delayed 2 clk to align with rgb_pixel.
REQ-021 rgb_out SHALL be 12'h000 when the aligned hblnk or vblnk is 1; else rgb_pixel when aligned in_sprite is 1; else the aligned rgb_in.
REQ-022 Blanking SHALL take priority over the sprite, and the sprite over the background.
REQ-023 A position change arriving on the same clk as a vblnk rising edge SHALL be captured on that edge.

Reset
REQ-024 While rst is 1 at a clk edge, all pipeline registers, pixel_addr, rgb_out, every timing output, xpos_r, ypos_r and the vblnk edge detector SHALL become 0.
REQ-025 Reset asserted mid-frame SHALL abort all in-flight pixels; after rst deasserts, outputs SHALL resume with the 3-clk latency.
REQ-026 The first latch after reset SHALL occur on the next vblnk rising edge; until then the sprite SHALL be drawn at (0,0).

Configuration
REQ-027 With macro BUG_TRANSPARENT_EN defined, a pixel where aligned in_sprite is 1 and rgb_pixel equals KEY_COLOR SHALL output the aligned rgb_in instead of rgb_pixel.
REQ-028 Without BUG_TRANSPARENT_EN, rgb_pixel SHALL be output for every in-sprite pixel regardless of value; KEY_COLOR SHALL then be unused.

Verification
REQ-029 xpos=100, ypos=50 latched; drive hcount=100, vcount=50 -> pixel_addr=12'h000 after 1 clk; ROM returning 12'hABC gives rgb_out=12'hABC 3 clk after input.
REQ-030 Same position; hcount=163, vcount=113 -> pixel_addr=12'hFFF; hcount=164 -> pixel_addr=12'h000 and rgb_out=rgb_in.
REQ-031 Change xpos from 100 to 300 mid-frame (vblnk=0) -> sprite remains at 100 until the next vblnk rising edge, then appears at 300.
REQ-032 xpos=1000 with hcount wrapping 1055->0 -> no sprite pixels at hcount 0..39.
REQ-033 BUG_TRANSPARENT_EN defined, rgb_pixel=12'hF0F, rgb_in=12'h123 -> rgb_out=12'h123; macro undefined -> rgb_out=12'hF0F.
REQ-034 Assert rst for 1 clk mid-line -> all outputs 0 on the following clk; in-sprite pixel at the reset point yields rgb_out=0, and correct output resumes 3 clk after rst deasserts.
